goldschmidt_round: RTL and testbench
====================================

Name: goldschmidt_round

Overview:
Post-processing stage directly downstream of the Goldschmidt divider datapath. It accepts the raw WIDTH-bit quotient and the two remainder flags (rem_sign, rem_zero) produced on the divider's remainder cycle. It applies the one-ulp correction, then rounds to OUTW bits under a selectable rounding mode. The result is presented on a valid/ready output interface to the consumer.
- Quotient format is unsigned fixed point: 2 integer bits, WIDTH-2 fraction bits.

Parameters:
- WIDTH, 30: width of the incoming divider quotient.
- OUTW, 24: width of the rounded result. Legal range 2 <= OUTW <= WIDTH-2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  quotient, rem_sign, rem_zero and rnd_mode are valid this cycle
- in_ready  output  1  block can accept a new quotient
- quotient  input  WIDTH  raw divider quotient q
- rem_sign  input  1  q*d > n, so q is one ulp too large
- rem_zero  input  1  q*d == n
- rnd_mode  input  2  00 = RZ (truncate), 01 = RNE, 10 = RU (toward +inf), 11 = reserved, treated as RZ
- result  output  OUTW  rounded quotient
- inexact  output  1  result differs from the true quotient
- ovf  output  1  rounding carried out of OUTW bits; result saturated
- out_valid  output  1  result, inexact and ovf are valid
- out_ready  input  1  consumer accepts the result
- overrun  output  1  sticky: in_valid was asserted while in_ready was 0

Behaviour:
- Reset values: FSM = IDLE; result = 0, inexact = 0, ovf = 0, out_valid = 0, overrun = 0; in_ready = 1 once reset is released.
- Reset asserted in any state aborts the operation in flight; the captured data is discarded.
- FSM states: IDLE, CORR, RND, HOLD. One operation in flight at a time.
- IDLE:
  - in_ready = 1.
  - When in_valid = 1: capture quotient, rem_sign, rem_zero and rnd_mode, then go to CORR. rnd_mode is sampled only here.
- CORR (1 cycle), always followed by RND:
  - q' = q - 1 if rem_sign, otherwise q'= q. Arithmetic is WIDTH-bit.
  - If rem_sign = 1 and q = 0, clamp q' to 0. No wrap-around.
  - exact = rem_zero & ~rem_sign. If both flags are set, rem_sign wins.
- RND (1 cycle), always followed by HOLD. Let D = WIDTH - OUTW.
  - hi = q'[WIDTH-1:D], lsb = hi[0], g = q'[D-1].
  - s = (D >= 2 ? |q'[D-2:0] : 0) | ~exact.
  - Round-up decision:
    - RZ: up = 0.
    - RNE: up = g & (s | lsb).
    - RU: up = g | s.
  - If up = 1 and hi is all ones: result = all ones, ovf = 1.
  - Otherwise: result = hi + up, ovf = 0.
  - inexact = g | s.
  - Register result, inexact and ovf.
- HOLD:
  - out_valid = 1; outputs are held stable while out_ready = 0.
  - When out_ready = 1: transition completes this edge, go to IDLE, out_valid = 0 next cycle.
- Latency: accept edge to out_valid = 2 cycles (CORR, then RND). Minimum initiation interval = 4 cycles, shorter than the 12-cycle divider schedule.
- in_ready is 0 in CORR, RND and HOLD.
- overrun:
  - Set on any edge where in_valid = 1 and in_ready = 0.
  - Cleared only by reset.
  - The offered input is dropped, and the in-flight operation is unaffected.
- in_valid in the same cycle HOLD completes is not accepted, because in_ready is still 0. It sets overrun.

Test Plan (WIDTH = 30, OUTW = 24):
- Exact: q = 30'h1000_0000, rem_zero = 1, RNE -> result = 24'h400000, inexact = 0, ovf = 0, out_valid rises 2 cycles after accept.
- Tie cases, rem_zero = 1, RNE:
  - q = 30'h1000_0020 -> result = 24'h400000 (even, no round), inexact = 1.
  - q = 30'h1000_0060 -> result = 24'h400002.
- Correction, q = 30'h1000_0000, rem_sign = 1:
  - RZ -> result = 24'h3FFFFF, inexact = 1.
  - RNE -> result = 24'h400000.
  - q = 0 with rem_sign = 1 -> result = 0, no wrap.
- Overflow: q = 30'h3FFF_FFFF, rem_zero = 0, RU -> result = 24'hFFFFFF, ovf = 1, inexact = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD and pulse in_valid -> result stable, in_ready = 0, overrun = 1. The pulsed input never appears. After out_ready = 1, out_valid drops and in_ready = 1.
- Reset mid-operation: assert reset in RND -> all outputs return to their reset values immediately. Next accepted input completes normally with 2-cycle latency.

Source files
------------

// File: rtl/goldschmidt_round_if.sv
// Valid/ready bundle between the divider, the rounding stage and its consumer.
interface goldschmidt_round_if #(
  parameter int WIDTH = 30,
  parameter int OUTW  = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] quotient;
  logic             rem_sign;
  logic             rem_zero;
  logic [1:0]       rnd_mode;
  logic [OUTW-1:0]  result;
  logic             inexact;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  // Driven by the divider/consumer side.
  modport master (
    output in_valid, quotient, rem_sign, rem_zero, rnd_mode, out_ready,
    input  in_ready, result, inexact, ovf, out_valid, overrun
  );

  // The rounding stage itself.
  modport slave (
    input  in_valid, quotient, rem_sign, rem_zero, rnd_mode, out_ready,
    output in_ready, result, inexact, ovf, out_valid, overrun
  );
endinterface

// File: rtl/goldschmidt_round.sv
// One-ulp quotient correction followed by RZ/RNE/RU rounding to OUTW bits.
// Quotient is unsigned fixed point with 2 integer bits. One operation in flight.
module goldschmidt_round #(
  parameter int WIDTH = 30,
  parameter int OUTW  = 24
) (
  input logic              clk,
  input logic              reset,
  goldschmidt_round_if.slave bus
);
  localparam int D = WIDTH - OUTW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CORR = 2'd1;
  localparam logic [1:0] S_RND  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [1:0] M_RNE = 2'b01;
  localparam logic [1:0] M_RU  = 2'b10;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;       // raw quotient, overwritten by the corrected value in CORR
  logic             r_sign;
  logic             r_zero;
  logic [1:0]       r_mode;
  logic             r_exact;
  logic [OUTW-1:0]  r_result;
  logic             r_inexact;
  logic             r_ovf;
  logic             r_overrun;

  logic             w_in_ready;
  logic [WIDTH-1:0] w_q_corr;
  logic [OUTW-1:0]  w_hi;
  logic             w_g;
  logic             w_low_sticky;
  logic             w_s;
  logic             w_up;

  assign w_in_ready = (r_state == S_IDLE);

  // Subtract one ulp when the remainder says q overshot; never wrap below zero.
  assign w_q_corr = r_sign ? ((r_q == '0) ? '0 : (r_q - WIDTH'(1))) : r_q;

  assign w_hi = r_q[WIDTH-1:D];
  assign w_g  = r_q[D-1];

  generate
    if (D >= 2) begin : g_sticky
      assign w_low_sticky = |r_q[D-2:0];
    end else begin : g_no_sticky
      assign w_low_sticky = 1'b0;
    end
  endgenerate

  // A nonzero remainder means the true quotient lies strictly above q'.
  assign w_s = w_low_sticky | ~r_exact;

  // Round-up decision; reserved mode falls through to truncation.
  always_comb begin
    w_up = 1'b0;
    case (r_mode)
      M_RNE:   w_up = w_g & (w_s | w_hi[0]);
      M_RU:    w_up = w_g | w_s;
      default: w_up = 1'b0;
    endcase
  end

  // Control FSM, operand capture, correction and rounding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_mode    <= 2'b00;
      r_exact   <= 1'b0;
      r_result  <= '0;
      r_inexact <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_q     <= bus.quotient;
            r_sign  <= bus.rem_sign;
            r_zero  <= bus.rem_zero;
            r_mode  <= bus.rnd_mode;
            r_state <= S_CORR;
          end
        end
        S_CORR: begin
          r_q     <= w_q_corr;
          r_exact <= r_zero & ~r_sign;
          r_state <= S_RND;
        end
        S_RND: begin
          if (w_up && (&w_hi)) begin
            r_result <= '1;
            r_ovf    <= 1'b1;
          end else begin
            r_result <= w_hi + OUTW'(w_up);
            r_ovf    <= 1'b0;
          end
          r_inexact <= w_g | w_s;
          r_state   <= S_HOLD;
        end
        default: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Sticky flag for inputs offered while busy; those inputs are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (bus.in_valid && !w_in_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.result    = r_result;
  assign bus.inexact   = r_inexact;
  assign bus.ovf       = r_ovf;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_goldschmidt_round.sv
// Scoreboard bench for goldschmidt_round: a driver pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_goldschmidt_round;
  localparam int W = 30;
  localparam int O = 24;
  localparam int D = W - O;

  typedef struct {
    logic [O-1:0] result;
    logic         inexact;
    logic         ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   txn;
  exp_t exp_q[$];

  goldschmidt_round_if #(.WIDTH(W), .OUTW(O)) bus ();

  goldschmidt_round #(.WIDTH(W), .OUTW(O)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: treat the true quotient as q' plus an infinitesimal when the
  // remainder is nonzero, then round the discarded tail against one half.
  function automatic exp_t model(input logic [W-1:0] q, input bit sg, input bit zr,
                                 input logic [1:0] m);
    exp_t   e;
    longint qp, hi, tail, half, maxv;
    bit     exact, above, tie, nonzero, up;
    qp    = sg ? ((q == 0) ? 0 : longint'(q) - 1) : longint'(q);
    exact = zr && !sg;
    hi    = qp / (longint'(1) << D);
    tail  = qp % (longint'(1) << D);
    half  = longint'(1) << (D - 1);
    maxv  = (longint'(1) << O) - 1;
    above   = (tail > half) || (tail == half && !exact);
    tie     = (tail == half) && exact;
    nonzero = (tail != 0) || !exact;
    case (m)
      2'b01:   up = above || (tie && (hi % 2 == 1));
      2'b10:   up = nonzero;
      default: up = 0;
    endcase
    if (up && hi == maxv) begin
      e.result = O'(maxv);
      e.ovf    = 1'b1;
    end else begin
      e.result = O'(hi + (up ? 1 : 0));
      e.ovf    = 1'b0;
    end
    e.inexact = nonzero;
    return e;
  endfunction

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result=%0h, expected no output", bus.result);
      end else begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: result=%06h inexact=%0b ovf=%0b", txn, bus.result, bus.inexact, bus.ovf);
        check("result", longint'(bus.result), longint'(e.result));
        check("inexact", longint'(bus.inexact), longint'(e.inexact));
        check("ovf", longint'(bus.ovf), longint'(e.ovf));
      end
    end
  end

  // Offer one input once in_ready is high; optionally verify the 2-cycle latency.
  task automatic send(input logic [W-1:0] q, input bit sg, input bit zr,
                      input logic [1:0] m, input bit push, input bit chk_lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check("wait_in_ready", 0, 1);
    bus.quotient = q;
    bus.rem_sign = sg;
    bus.rem_zero = zr;
    bus.rnd_mode = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back(model(q, sg, zr, m));
    #1;
    bus.in_valid = 1'b0;
    if (chk_lat) begin
      check("lat_corr_valid", longint'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_rnd_valid", longint'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_hold_valid", longint'(bus.out_valid), 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_result"}, longint'(bus.result), 0);
    check({tag, "_inexact"}, longint'(bus.inexact), 0);
    check({tag, "_ovf"}, longint'(bus.ovf), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_overrun"}, longint'(bus.overrun), 0);
  endtask

  initial begin
    logic [O-1:0] held;
    int n;
    total = 0;
    bad = 0;
    txn = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.rem_sign  = 1'b0;
    bus.rem_zero  = 1'b0;
    bus.rnd_mode  = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("rst");
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // Directed cases with latency checks.
    send(30'h1000_0000, 0, 1, 2'b01, 1, 1); drain();
    send(30'h1000_0020, 0, 1, 2'b01, 1, 1); drain();
    send(30'h1000_0060, 0, 1, 2'b01, 1, 1); drain();
    send(30'h1000_0000, 1, 0, 2'b00, 1, 1); drain();
    send(30'h1000_0000, 1, 0, 2'b01, 1, 1); drain();
    send(30'h0000_0000, 1, 0, 2'b10, 1, 1); drain();
    send(30'h0000_0000, 1, 1, 2'b01, 1, 1); drain();
    send(30'h3FFF_FFFF, 0, 0, 2'b10, 1, 1); drain();
    send(30'h3FFF_FFE0, 0, 1, 2'b11, 1, 1); drain();

    // Backpressure: hold HOLD for 5 cycles and offer an input that must be dropped.
    bus.out_ready = 1'b0;
    send(30'h2345_6789, 0, 0, 2'b01, 1, 1);
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.quotient = 30'h0ABC_DEF0;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_out_valid", longint'(bus.out_valid), 1);
      check("bp_result_stable", longint'(bus.result), longint'(held));
      check("bp_in_ready", longint'(bus.in_ready), 0);
    end
    check("bp_overrun", longint'(bus.overrun), 1);
    // In_valid in the completing cycle is also refused.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.quotient  = 30'h1111_1111;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_done_out_valid", longint'(bus.out_valid), 0);
    check("bp_done_in_ready", longint'(bus.in_ready), 1);
    check("bp_queue_empty", longint'(exp_q.size()), 0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_ghost", longint'(bus.out_valid), 0);

    // Reset while in RND aborts the operation.
    send(30'h3333_3333, 0, 0, 2'b10, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    check("midrst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(30'h1555_5555, 0, 0, 2'b01, 1, 1); drain();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_ghost", longint'(bus.out_valid), 0);

    // Randomized operations with random consumer stalls.
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] q;
      int sel;
      sel = $urandom_range(0, 9);
      q = W'($urandom);
      if (sel == 0) q = '0;
      if (sel == 1) q = '1;
      if (sel == 2) q[D-1:0] = W'(1) << (D - 1);
      send(q, 1'($urandom), 1'($urandom), 2'($urandom), 1, 0);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        bus.out_ready = 1'($urandom);
        @(posedge clk);
        #1;
        n++;
      end
      drain();
    end

    drain();
    check("final_queue_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
